// File: rtl/sd_pkg.sv
// Shared SD board definitions: sdcard types plus the IRQ register page.
// Holds register offsets, bit indices and the IRQ bus FSM encoding.
package sd_pkg;

  typedef enum logic [1:0] {
    SD_CARD_NONE = 2'd0,
    SD_CARD_SDSC = 2'd1,
    SD_CARD_SDHC = 2'd2
  } sd_card_e;

  typedef struct packed {
    logic       busy;
    logic       crc_err;
    sd_card_e   card;
  } sd_status_t;

  localparam logic [7:0] IRQ_OFF_STATUS = 8'h00;
  localparam logic [7:0] IRQ_OFF_MASK   = 8'h02;

  localparam int ST_INS     = 0;
  localparam int ST_REM     = 1;
  localparam int ST_CTRL    = 2;
  localparam int ST_PRESENT = 8;
  localparam int MSK_GLOBAL = 15;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_HOLD = 2'd2
  } irq_bus_e;

endpackage

// File: rtl/cd_debounce.sv
// Card-detect debouncer: level plus one-cycle rise/fall pulses.
// Ports: CLKCPU, RESET_n, cd_i (synchronised), level_o, rise_o, fall_o.
module cd_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic CLKCPU,
  input  logic RESET_n,
  input  logic cd_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic        sample_q, sample_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;

  always_comb begin
    sample_d = sample_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (cd_i != sample_q) begin
      sample_d = cd_i;
      cnt_d    = '0;
    end else if (cnt_q != CYCLES - 16'd1) begin
      cnt_d = cnt_q + 16'd1;
    end else if (level_q != sample_q) begin
      // window complete and input stable: commit
      level_d = sample_q;
      rise_d  = sample_q;
      fall_d  = ~sample_q;
    end
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      sample_q <= 1'b1;
      cnt_q    <= '0;
      level_q  <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sd_irq_ctrl.sv
// SD board IRQ controller: STATUS/MASK page, card-detect and INT2 drive.
// Ports: CPU bus (AS/DS/RW/A/D), SD_INT_n, CD_n, DTACK_n, INT2 open-drain.
module sd_irq_ctrl
  import sd_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  REG_PAGE        = 8'hFF
) (
  input  logic        CLKCPU,
  input  logic        RESET_n,
  input  logic        AS_CPU_n,
  input  logic        DS_n,
  input  logic        RW_n,
  input  logic [23:1] A,
  input  logic [7:0]  BASE_SD,
  input  logic        SD_CONFIGURED_n,
  input  logic        SD_INT_n,
  input  logic        CD_n,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        DATA_OE,
  output logic        IRQ_ACCESS,
  output logic        DTACK_n,
  output logic        INT2_n_OUT,
  output logic        INT2_n_OE
);

  logic cd_s1_q, cd_s2_q;
  logic int_s1_q, int_s2_q, int_prev_q;

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      cd_s1_q    <= 1'b1;
      cd_s2_q    <= 1'b1;
      int_s1_q   <= 1'b1;
      int_s2_q   <= 1'b1;
      int_prev_q <= 1'b1;
    end else begin
      cd_s1_q    <= CD_n;
      cd_s2_q    <= cd_s1_q;
      int_s1_q   <= SD_INT_n;
      int_s2_q   <= int_s1_q;
      int_prev_q <= int_s2_q;
    end
  end

  logic cd_lvl, cd_rise, cd_fall;

  cd_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_cd_debounce (
    .CLKCPU  (CLKCPU),
    .RESET_n (RESET_n),
    .cd_i    (cd_s2_q),
    .level_o (cd_lvl),
    .rise_o  (cd_rise),
    .fall_o  (cd_fall)
  );

  // only the falling edge counts, so a held-low request
  // cannot re-arm bit2 once software clears it
  logic int_fall;
  assign int_fall = int_prev_q & ~int_s2_q;

  assign IRQ_ACCESS = !SD_CONFIGURED_n
                    && A[23:16] == BASE_SD
                    && A[15:8] == REG_PAGE
                    && !AS_CPU_n;

  logic [7:0] off;
  logic       sel_stat, sel_mask;
  assign off      = {A[7:1], 1'b0};
  assign sel_stat = off == IRQ_OFF_STATUS;
  assign sel_mask = off == IRQ_OFF_MASK;

  logic [2:0] pend_q, pend_d;
  logic [2:0] mask_q, mask_d;
  logic       gl_q, gl_d;
  logic       int2_q, int2_d;

  logic [15:0] stat_w, mask_w, rd_mux;

  always_comb begin
    stat_w = '0;
    stat_w[ST_CTRL:ST_INS] = pend_q;
    stat_w[ST_PRESENT] = ~cd_lvl;
    mask_w = '0;
    mask_w[2:0] = mask_q;
    mask_w[MSK_GLOBAL] = gl_q;
    rd_mux = '0;
    if (sel_stat) rd_mux = stat_w;
    else if (sel_mask) rd_mux = mask_w;
  end

  irq_bus_e    state_q, state_d;
  logic        rd_q, rd_d;
  logic [15:0] rdata_q, rdata_d;
  logic        wr_stat, wr_mask;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    wr_stat = 1'b0;
    wr_mask = 1'b0;
    if (AS_CPU_n) begin
      state_d = BUS_IDLE;
      rd_d    = 1'b0;
    end else begin
      unique case (state_q)
        BUS_IDLE: begin
          if (IRQ_ACCESS && !DS_n) begin
            state_d = BUS_ACK;
            rd_d    = RW_n;
            rdata_d = RW_n ? rd_mux : 16'h0000;
            wr_stat = !RW_n && sel_stat;
            wr_mask = !RW_n && sel_mask;
          end
        end
        BUS_ACK:  state_d = BUS_HOLD;
        BUS_HOLD: state_d = BUS_HOLD;
        default:  state_d = BUS_IDLE;
      endcase
    end
  end

  logic [2:0] pend_set, pend_clr;
  assign pend_set = {int_fall, cd_rise, cd_fall};
  assign pend_clr = wr_stat ? D_IN[2:0] : 3'b000;

  always_comb begin
    // set is ORed in last so it wins over a same-cycle clear
    pend_d = (pend_q & ~pend_clr) | pend_set;
    mask_d = wr_mask ? D_IN[2:0] : mask_q;
    gl_d   = wr_mask ? D_IN[MSK_GLOBAL] : gl_q;
    int2_d = gl_q && |(pend_q & mask_q);
  end

  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= BUS_IDLE;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      gl_q    <= 1'b0;
      int2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      gl_q    <= gl_d;
      int2_q  <= int2_d;
    end
  end

  logic acking;
  assign acking = (state_q == BUS_ACK || state_q == BUS_HOLD)
                && !SD_CONFIGURED_n;

  assign DTACK_n    = !acking;
  assign DATA_OE    = acking && rd_q;
  assign D_OUT      = DATA_OE ? rdata_q : 16'h0000;
  assign INT2_n_OUT = 1'b0;
  assign INT2_n_OE  = int2_q;

  logic unused_din;
  assign unused_din = ^D_IN[14:3];

endmodule

// File: tb/tb_sd_irq_ctrl.sv
// Directed bench for sd_irq_ctrl with a read-data scoreboard.
// Ports: drives every DUT port; DEBOUNCE_CYCLES reduced to 8.
module tb_sd_irq_ctrl;

  localparam logic [15:0] DEB = 16'd8;
  // CD_n change -> 2 sync -> sample -> DEB count -> level -> pending
  localparam int K = int'(DEB) + 4;

  localparam logic [23:0] AD_STAT = 24'hE9FF00;
  localparam logic [23:0] AD_MASK = 24'hE9FF02;

  logic        CLKCPU = 1'b0;
  logic        RESET_n = 1'b0;
  logic        AS_CPU_n = 1'b1;
  logic        DS_n = 1'b1;
  logic        RW_n = 1'b1;
  logic [23:1] A = '0;
  logic [7:0]  BASE_SD = 8'hE9;
  logic        SD_CONFIGURED_n = 1'b0;
  logic        SD_INT_n = 1'b1;
  logic        CD_n = 1'b1;
  logic [15:0] D_IN = '0;
  logic [15:0] D_OUT;
  logic        DATA_OE, IRQ_ACCESS, DTACK_n;
  logic        INT2_n_OUT, INT2_n_OE;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 CLKCPU = ~CLKCPU;

  sd_irq_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .REG_PAGE        (8'hFF)
  ) dut (
    .CLKCPU          (CLKCPU),
    .RESET_n         (RESET_n),
    .AS_CPU_n        (AS_CPU_n),
    .DS_n            (DS_n),
    .RW_n            (RW_n),
    .A               (A),
    .BASE_SD         (BASE_SD),
    .SD_CONFIGURED_n (SD_CONFIGURED_n),
    .SD_INT_n        (SD_INT_n),
    .CD_n            (CD_n),
    .D_IN            (D_IN),
    .D_OUT           (D_OUT),
    .DATA_OE         (DATA_OE),
    .IRQ_ACCESS      (IRQ_ACCESS),
    .DTACK_n         (DTACK_n),
    .INT2_n_OUT      (INT2_n_OUT),
    .INT2_n_OE       (INT2_n_OE)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // caller is at a negedge; returns two negedges later
  task automatic bus_rd(input logic [23:0] ba,
                        input logic [15:0] exp,
                        input string tag);
    logic [15:0] e;
    A = ba[23:1];
    RW_n = 1'b1;
    AS_CPU_n = 1'b0;
    DS_n = 1'b0;
    sb.push_back(exp);
    #1 check({tag, "_acc"}, IRQ_ACCESS, 1);
    @(negedge CLKCPU);
    check({tag, "_dtack0"}, DTACK_n, 0);
    check({tag, "_oe"}, DATA_OE, 1);
    e = sb.pop_front();
    check(tag, D_OUT, e);
    AS_CPU_n = 1'b1;
    DS_n = 1'b1;
    @(negedge CLKCPU);
    check({tag, "_dtack1"}, DTACK_n, 1);
    check({tag, "_oe0"}, DATA_OE, 0);
  endtask

  task automatic bus_wr(input logic [23:0] ba,
                        input logic [15:0] d,
                        input string tag,
                        output logic i2_mid);
    A = ba[23:1];
    RW_n = 1'b0;
    D_IN = d;
    AS_CPU_n = 1'b0;
    DS_n = 1'b0;
    #1 check({tag, "_acc"}, IRQ_ACCESS, 1);
    @(negedge CLKCPU);
    check({tag, "_dtack0"}, DTACK_n, 0);
    check({tag, "_oe"}, DATA_OE, 0);
    i2_mid = INT2_n_OE;
    AS_CPU_n = 1'b1;
    DS_n = 1'b1;
    RW_n = 1'b1;
    @(negedge CLKCPU);
    check({tag, "_dtack1"}, DTACK_n, 1);
  endtask

  initial begin
    logic i2;
    #1;
    check("rst_dtack", DTACK_n, 1);
    check("rst_oe", DATA_OE, 0);
    check("rst_dout", D_OUT, 0);
    check("rst_int2", INT2_n_OE, 0);
    check("rst_int2out", INT2_n_OUT, 0);
    check("rst_acc", IRQ_ACCESS, 0);
    repeat (2) @(negedge CLKCPU);
    RESET_n = 1'b1;
    @(negedge CLKCPU);
    bus_rd(AD_STAT, 16'h0000, "st_reset");
    bus_rd(AD_MASK, 16'h0000, "mask_reset");

    // short glitch on card detect
    CD_n = 1'b0;
    repeat (5) @(negedge CLKCPU);
    CD_n = 1'b1;
    repeat (20) @(negedge CLKCPU);
    bus_rd(AD_STAT, 16'h0000, "st_glitch");

    // insertion with bit0 enabled
    bus_wr(AD_MASK, 16'h8001, "wr_m1", i2);
    CD_n = 1'b0;
    repeat (K) @(negedge CLKCPU);
    check("int2_ins_pre", INT2_n_OE, 0);
    @(negedge CLKCPU);
    check("int2_ins", INT2_n_OE, 1);
    repeat (20 - K - 1) @(negedge CLKCPU);
    bus_rd(AD_STAT, 16'h0101, "st_ins");

    // controller request, cleared while still low
    bus_wr(AD_MASK, 16'h8004, "wr_m4", i2);
    check("int2_m4", INT2_n_OE, 0);
    SD_INT_n = 1'b0;
    repeat (6) @(negedge CLKCPU);
    check("int2_ctrl", INT2_n_OE, 1);
    bus_wr(AD_STAT, 16'h0004, "wr_clr2", i2);
    check("int2_mid", i2, 1);
    check("int2_fall", INT2_n_OE, 0);
    repeat (10) @(negedge CLKCPU);
    check("int2_held", INT2_n_OE, 0);
    bus_rd(AD_STAT, 16'h0101, "st_ctrl");
    SD_INT_n = 1'b1;
    repeat (4) @(negedge CLKCPU);

    // removal completes in the same cycle bit0 is cleared
    CD_n = 1'b1;
    repeat (K - 1) @(negedge CLKCPU);
    bus_wr(AD_STAT, 16'h0001, "wr_rm", i2);
    bus_rd(AD_STAT, 16'h0002, "st_rm");

    // insertion sets bit0 in the same cycle it is cleared
    CD_n = 1'b0;
    repeat (K - 1) @(negedge CLKCPU);
    bus_wr(AD_STAT, 16'h0001, "wr_ins2", i2);
    bus_rd(AD_STAT, 16'h0103, "st_ins2");

    // mask readback and bus timing
    bus_wr(AD_MASK, 16'h8007, "wr_m7", i2);
    bus_rd(AD_MASK, 16'h8007, "mask_rd");
    check("int2_m7", INT2_n_OE, 1);
    bus_rd(24'hE9FF10, 16'h0000, "other_off");

    // wrong page
    A = 23'(24'hE90002 >> 1);
    AS_CPU_n = 1'b0;
    DS_n = 1'b0;
    #1 check("acc_page", IRQ_ACCESS, 0);
    @(negedge CLKCPU);
    check("dtack_page", DTACK_n, 1);
    AS_CPU_n = 1'b1;
    DS_n = 1'b1;
    @(negedge CLKCPU);

    // board unconfigured: no access, events still latch
    SD_CONFIGURED_n = 1'b1;
    A = AD_STAT[23:1];
    AS_CPU_n = 1'b0;
    DS_n = 1'b0;
    SD_INT_n = 1'b0;
    #1 check("acc_uncfg", IRQ_ACCESS, 0);
    @(negedge CLKCPU);
    check("dtack_uncfg", DTACK_n, 1);
    AS_CPU_n = 1'b1;
    DS_n = 1'b1;
    repeat (3) @(negedge CLKCPU);
    SD_INT_n = 1'b1;
    repeat (4) @(negedge CLKCPU);
    SD_CONFIGURED_n = 1'b0;
    bus_rd(AD_STAT, 16'h0107, "st_uncfg");

    // reset during HOLD
    A = AD_MASK[23:1];
    RW_n = 1'b1;
    AS_CPU_n = 1'b0;
    DS_n = 1'b0;
    repeat (2) @(negedge CLKCPU);
    check("hold_dtack", DTACK_n, 0);
    check("hold_oe", DATA_OE, 1);
    #2 RESET_n = 1'b0;
    #1;
    check("arst_dtack", DTACK_n, 1);
    check("arst_oe", DATA_OE, 0);
    check("arst_dout", D_OUT, 0);
    check("arst_int2", INT2_n_OE, 0);
    @(negedge CLKCPU);
    AS_CPU_n = 1'b1;
    DS_n = 1'b1;
    RESET_n = 1'b1;
    @(negedge CLKCPU);
    bus_rd(AD_MASK, 16'h0000, "mask_arst");

    // card present through reset gives a bit0 event
    repeat (K + 4) @(negedge CLKCPU);
    bus_rd(AD_STAT, 16'h0101, "st_arst");
    check("int2_arst", INT2_n_OE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
